stream_demultiplexer: RTL and testbench

//  1-to-4 demultiplexer with registered outputs: one valid/ready input stream, routed by a 2-bit address.

---
 rtl/demux_pkg.sv | 12 +
 rtl/demux_channel_slot.sv | 70 +++++++
 rtl/stream_demultiplexer.sv | 61 ++++++
 tb/tb_stream_demultiplexer.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/demux_pkg.sv
// Shared constants and channel state encoding for the 1-to-4 stream demultiplexer.
package demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned ADDR_W = 2;

  typedef enum logic {
    CH_EMPTY = 1'b0,
    CH_FULL  = 1'b1
  } ch_state_e;

endpackage

// File: rtl/demux_channel_slot.sv
// One-entry output buffer for a single demux channel, with an optional drain counter
// (present when DEMUX_BEAT_CNT_EN is defined).
module demux_channel_slot
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             drain,
  input  logic [WIDTH-1:0] load_data,
  output logic             valid,
  output logic [WIDTH-1:0] buf_data
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [CNT_W-1:0] count
`endif
);

  ch_state_e state_q, state_d;
  logic [WIDTH-1:0] data_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= CH_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A load wins over a simultaneous drain: the old beat leaves, the new one stays.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CH_EMPTY: if (load) state_d = CH_FULL;
      CH_FULL:  if (drain && !load) state_d = CH_EMPTY;
      default:  state_d = CH_EMPTY;
    endcase
  end

  always_comb begin
    valid    = (state_q == CH_FULL);
    buf_data = data_q;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= load_data;
    end
  end

`ifdef DEMUX_BEAT_CNT_EN
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (drain) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;
`endif

endmodule

// File: rtl/stream_demultiplexer.sv
// 1-to-4 valid/ready demultiplexer with one registered beat per output channel.
// Optional per-channel drain counters are enabled by defining DEMUX_BEAT_CNT_EN.
module stream_demultiplexer
  import demux_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [WIDTH-1:0]        in_data,
  input  logic                    address0,
  input  logic                    address1,
  output logic [NUM_CH-1:0]       out_valid,
  input  logic [NUM_CH-1:0]       out_ready,
  output logic [NUM_CH*WIDTH-1:0] out_data
`ifdef DEMUX_BEAT_CNT_EN
  ,
  output logic [NUM_CH*CNT_W-1:0] beat_count
`endif
);

  if (WIDTH == 0 || CNT_W == 0) begin : g_bad_param
    $error("stream_demultiplexer: WIDTH and CNT_W must be non-zero");
  end

  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] drain;

  assign addr     = {address1, address0};
  // Ready only looks at the addressed slot so a stalled lane never blocks the others.
  assign in_ready = !out_valid[addr] || out_ready[addr];
  assign accept   = in_valid && in_ready;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    assign load[k]  = accept && (addr == ADDR_W'(k));
    assign drain[k] = out_valid[k] && out_ready[k];

    demux_channel_slot #(
      .WIDTH (WIDTH),
      .CNT_W (CNT_W)
    ) u_slot (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load[k]),
      .drain     (drain[k]),
      .load_data (in_data),
      .valid     (out_valid[k]),
      .buf_data  (out_data[k*WIDTH +: WIDTH])
`ifdef DEMUX_BEAT_CNT_EN
      ,
      .count     (beat_count[k*CNT_W +: CNT_W])
`endif
    );
  end

endmodule

// File: tb/tb_stream_demultiplexer.sv
// Self-checking bench for stream_demultiplexer: vector table plus scoreboarded sequences.
module tb_stream_demultiplexer;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             address0;
  logic             address1;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [4*WIDTH-1:0] out_data;
`ifdef DEMUX_BEAT_CNT_EN
  logic [4*CNT_W-1:0] beat_count;
`endif

  always #5 clk = ~clk;

  stream_demultiplexer #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .address0  (address0),
    .address1  (address1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef DEMUX_BEAT_CNT_EN
    ,
    .beat_count (beat_count)
`endif
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: per-lane expected beat queues, full bits and drain counts.
  logic [WIDTH-1:0] sb_q [4][$];
  logic [3:0]       mv;
  int unsigned      mcnt [4];
  int               lane2_pops;

  typedef struct {
    logic             v;
    logic [1:0]       a;
    logic [WIDTH-1:0] d;
    logic [3:0]       ordy;
    logic             exp_rdy;
    logic [3:0]       exp_ov;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] lane(input int k);
    return out_data[k*WIDTH +: WIDTH];
  endfunction

  task automatic model_clear();
    mv = '0;
    for (int k = 0; k < 4; k++) begin
      sb_q[k].delete();
      mcnt[k] = 0;
    end
  endtask

  // Drive one cycle; check against the model just before the edge, then advance.
  task automatic step(input logic v, input logic [1:0] a, input logic [WIDTH-1:0] d,
                      input logic [3:0] ordy, input logic rst_n, output logic rdy_seen);
    logic       exp_rdy;
    logic [3:0] nv;
    logic [WIDTH-1:0] exp_d;
    in_valid = v;
    {address1, address0} = a;
    in_data   = d;
    out_ready = ordy;
    reset_n   = rst_n;
    #1;
    rdy_seen = in_ready;
    if (rst_n) begin
      exp_rdy = !mv[a] || ordy[a];
      check("in_ready", in_ready, exp_rdy);
      check("out_valid", out_valid, mv);
      nv = mv;
      for (int k = 0; k < 4; k++) begin
        if (mv[k] && ordy[k]) begin
          if (sb_q[k].size() == 0) begin
            check($sformatf("lane%0d_underflow", k), 1, 0);
          end else begin
            exp_d = sb_q[k].pop_front();
            check($sformatf("lane%0d_data", k), lane(k), exp_d);
          end
          mcnt[k]++;
          if (k == 2) lane2_pops++;
          nv[k] = 1'b0;
        end
      end
      if (v && exp_rdy) begin
        sb_q[a].push_back(d);
        nv[a] = 1'b1;
      end
      mv = nv;
    end else begin
      model_clear();
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic rdy;
    model_clear();
    lane2_pops = 0;

    tbl[0] = '{1'b1, 2'd0, 8'hA0, 4'b0000, 1'b1, 4'b0001};
    tbl[1] = '{1'b1, 2'd1, 8'hA1, 4'b0000, 1'b1, 4'b0011};
    tbl[2] = '{1'b1, 2'd2, 8'hA2, 4'b0000, 1'b1, 4'b0111};
    tbl[3] = '{1'b1, 2'd3, 8'hA3, 4'b0000, 1'b1, 4'b1111};
    tbl[4] = '{1'b1, 2'd1, 8'hB1, 4'b0000, 1'b0, 4'b1111};
    tbl[5] = '{1'b1, 2'd1, 8'hB1, 4'b0010, 1'b1, 4'b1111};
    tbl[6] = '{1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, 4'b1111};

    // Reset held two cycles with in_valid asserted.
    step(1'b1, 2'd0, 8'h55, 4'b0000, 1'b0, rdy);
    step(1'b1, 2'd0, 8'h55, 4'b0000, 1'b0, rdy);
    check("reset_out_valid", out_valid, 4'b0000);
    check("reset_out_data", out_data, 32'h0);
`ifdef DEMUX_BEAT_CNT_EN
    check("reset_beat_count", beat_count, 16'h0);
`endif

    // Routing and backpressure vectors.
    for (int i = 0; i < 7; i++) begin
      step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].ordy, 1'b1, rdy);
      check($sformatf("vec%0d_in_ready", i), rdy, tbl[i].exp_rdy);
      check($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].exp_ov);
      if (i == 4) check("stall_lane1_hold", lane(1), 8'hA1);
      if (i == 5) check("swap_lane1_new", lane(1), 8'hB1);
    end
    check("route_lane0", lane(0), 8'hA0);
    check("route_lane2", lane(2), 8'hA2);
    check("route_lane3", lane(3), 8'hA3);

    // Back-to-back throughput on lane 2.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 2'd2, WIDTH'(i), 4'b1111, 1'b1, rdy);
      check($sformatf("thru%0d_in_ready", i), rdy, 1'b1);
      check($sformatf("thru%0d_lane2_valid", i), out_valid[2], 1'b1);
    end
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, rdy);
    check("thru_lane2_pops", lane2_pops, 17);
    check("thru_drained", out_valid, 4'b0000);
    check("drain_keeps_lane2", lane(2), 8'h0F);

    // Lane 3 stalled while lane 0 streams.
    step(1'b1, 2'd3, 8'hC3, 4'b0000, 1'b1, rdy);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 2'd0, 8'hD0 + WIDTH'(i), 4'b0001, 1'b1, rdy);
    end
    step(1'b1, 2'd3, 8'hEE, 4'b0001, 1'b1, rdy);
    check("indep_lane3_blocked", rdy, 1'b0);
    check("indep_lane3_hold", lane(3), 8'hC3);
    check("indep_lane3_valid", out_valid[3], 1'b1);
    check("indep_lane1_untouched", lane(1), 8'hB1);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, rdy);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, rdy);
    check("indep_all_drained", out_valid, 4'b0000);

`ifdef DEMUX_BEAT_CNT_EN
    // Counter wrap: 17 drains on lane 1 with a 4-bit counter.
    step(1'b0, 2'd0, 8'h00, 4'b0000, 1'b0, rdy);
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 2'd1, WIDTH'(i), 4'b0010, 1'b1, rdy);
    end
    step(1'b0, 2'd0, 8'h00, 4'b0010, 1'b1, rdy);
    check("cnt_lane1_wrap", beat_count[1*CNT_W +: CNT_W], 4'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("cnt_lane%0d_model", k), beat_count[k*CNT_W +: CNT_W], CNT_W'(mcnt[k]));
    end
`endif

    // Mid-stream reset discards buffered beats.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'(i), 8'h70 + WIDTH'(i), 4'b0001, 1'b1, rdy);
    end
    step(1'b1, 2'd3, 8'h77, 4'b0000, 1'b0, rdy);
    check("midrst_out_valid", out_valid, 4'b0000);
    check("midrst_out_data", out_data, 32'h0);
`ifdef DEMUX_BEAT_CNT_EN
    check("midrst_beat_count", beat_count, 16'h0);
`endif
    step(1'b1, 2'd2, 8'h99, 4'b0000, 1'b1, rdy);
    check("post_rst_load", lane(2), 8'h99);
    step(1'b0, 2'd0, 8'h00, 4'b1111, 1'b1, rdy);
    check("final_sb_empty", sb_q[0].size() + sb_q[1].size() + sb_q[2].size() + sb_q[3].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
